decode_execute_stage: RTL and testbench
=======================================

// Module: decode_execute_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the register file.
//  - Captures the three read operands, their addresses and decode control into the Execute (E) stage.
//  - Forwards results from MEM/WB into the E operands.
//  - Bypasses same-cycle WB writes into the captured operands.
//  - Detects load-use hazards, inserting a bubble and stalling fetch/decode.
// PARAMETERS
//  CTRL_W  8  width of opaque decode control bundle passed through to E
//  FWD_EN  1  1 = MEM/WB forwarding enabled; 0 = raw registered operands (debug)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  d_valid      in   1       decode slot holds a real instruction
//  d_ra1/2/3    in   4       register-file read addresses (15 = PC, never forwarded)
//  d_rd1/2/3    in   32      register-file read data
//  d_wa         in   4       destination register of decode instruction
//  d_regwrite   in   1       decode instruction writes d_wa
//  d_memtoreg   in   1       decode instruction is a load (LDR)
//  d_ctrl       in   CTRL_W  remaining control, passed through untouched
//  m_wa         in   4       MEM-stage destination
//  m_regwrite   in   1       MEM-stage writes m_wa
//  m_result     in   32      MEM-stage ALU result
//  w_wa         in   4       WB-stage destination (same bus as register-file write port)
//  w_regwrite   in   1       WB-stage write enable
//  w_result     in   32      WB-stage write data
//  flush_e      in   1       branch taken: kill instruction entering E
//  stall_d      out  1       hold fetch/decode this cycle (load-use)
//  e_valid      out  1       E stage holds a real instruction
//  e_op1/2/3    out  32      forwarded operands for execute
//  e_wa         out  4       registered destination
//  e_regwrite   out  1       registered, gated by e_valid
//  e_memtoreg   out  1       registered, gated by e_valid
//  e_ctrl       out  CTRL_W  registered control
// BEHAVIOUR
//  Reset (async, any time): all E registers = 0, e_valid = 0, stall_d = 0.
//  - Any in-flight instruction is discarded, with no partial update.
//  Capture, every rising edge:
//  - Each d_rdN is replaced by w_result when w_regwrite & w_wa==d_raN & d_raN!=15.
//  - This covers the register file writing on the same edge.
//  Load-use hazard (combinational):
//  - lduse = e_valid & e_memtoreg & d_valid & (e_wa==d_raN for any N, d_raN!=15).
//  - stall_d = lduse & ~flush_e.
//  Next E state, in priority order:
//  - flush_e: bubble.
//  - lduse: bubble, with decode held upstream.
//  - otherwise: capture decode (e_valid <= d_valid).
//  Bubble: e_valid=0 and e_regwrite=e_memtoreg=0. Data registers may hold stale values.
//  Forwarding (combinational on E outputs, FWD_EN=1), per operand N:
//  - If e_raN!=15 & m_regwrite & m_wa==e_raN: use m_result.
//  - Else if e_raN!=15 & w_regwrite & w_wa==e_raN: use w_result.
//  - Else: use the registered operand.
//  - MEM has priority over WB.
//  A load in MEM is never forwarded from m_result. lduse guarantees it is not needed.
//  Latency: one cycle decode -> E. A load-use stall costs exactly one bubble cycle.
//  Simultaneous events:
//  - flush_e & lduse: flush wins and stall_d = 0.
//  - Both m and w match: m wins.
//  - d_raN==15: PC value passes through unmodified.
//  Back-to-back stalls: after a bubble, e_valid=0 so lduse clears. At most 1 stall per load.
// TESTING
//  1 Reset mid-stream -> all outputs 0, e_valid 0, on the same cycle, before the next clock.
//  2 ADD r1 in MEM (m_result=0x11), SUB r1 in WB (w_result=0x22), E reads r1 -> e_op1=0x11.
//  3 WB writes r3=0xDEAD on the edge decode reads r3 -> E captures 0xDEAD, not the stale value.
//  4 LDR r2 in E, decode reads r2 -> stall_d=1 for one cycle, bubble in E; next cycle captures normally.
//  5 LDR r2 in E + dependent decode + flush_e=1 -> stall_d=0, e_valid=0 next cycle.
//  6 Decode reads r15 while m_wa=15 & m_regwrite -> e_op = raw d_rd value, no forwarding.

Source files
------------

// File: rtl/decode_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_execute_stage
// Purpose  : ID/EX register with WB write-through, MEM/WB operand forwarding
//            and load-use bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module decode_execute_stage #(
   parameter int CTRL_W = 8,
   parameter bit FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [3:0]        d_ra1,
   input  logic [3:0]        d_ra2,
   input  logic [3:0]        d_ra3,
   input  logic [31:0]       d_rd1,
   input  logic [31:0]       d_rd2,
   input  logic [31:0]       d_rd3,
   input  logic [3:0]        d_wa,
   input  logic              d_regwrite,
   input  logic              d_memtoreg,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [3:0]        m_wa,
   input  logic              m_regwrite,
   input  logic [31:0]       m_result,
   input  logic [3:0]        w_wa,
   input  logic              w_regwrite,
   input  logic [31:0]       w_result,
   input  logic              flush_e,
   output logic              stall_d,
   output logic              e_valid,
   output logic [31:0]       e_op1,
   output logic [31:0]       e_op2,
   output logic [31:0]       e_op3,
   output logic [3:0]        e_wa,
   output logic              e_regwrite,
   output logic              e_memtoreg,
   output logic [CTRL_W-1:0] e_ctrl
);

   localparam logic [3:0] c_pc_addr = 4'd15;

   logic [2:0][3:0]  w_d_ra;
   logic [2:0][31:0] w_d_rd;
   logic [2:0][31:0] w_cap_rd;
   logic [2:0][31:0] w_e_op;
   logic [2:0]       w_ld_hit;
   logic             w_lduse;

   logic              r_e_valid;
   logic              r_e_regwrite;
   logic              r_e_memtoreg;
   logic [3:0]        r_e_wa;
   logic [CTRL_W-1:0] r_e_ctrl;
   logic [2:0][3:0]   r_e_ra;
   logic [2:0][31:0]  r_e_rd;

   assign w_d_ra = {d_ra3, d_ra2, d_ra1};
   assign w_d_rd = {d_rd3, d_rd2, d_rd1};

   always_comb begin
      w_ld_hit = '0;
      for (int n = 0; n < 3; n++) begin
         w_ld_hit[n] = (w_d_ra[n] != c_pc_addr) && (w_d_ra[n] == r_e_wa);
      end
   end

   assign w_lduse = r_e_valid & r_e_memtoreg & d_valid & (|w_ld_hit);
   assign stall_d = w_lduse & ~flush_e;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_op
         // Register file writes on the same edge we sample it, so emulate write-through.
         assign w_cap_rd[gi] = (w_regwrite && (w_wa == w_d_ra[gi]) && (w_d_ra[gi] != c_pc_addr))
                               ? w_result : w_d_rd[gi];

         if (FWD_EN) begin : g_fwd
            logic w_m_hit;
            logic w_w_hit;
            // Forwarding only matters for a live instruction; bubbles show the raw register.
            assign w_m_hit = r_e_valid && (r_e_ra[gi] != c_pc_addr) && m_regwrite && (m_wa == r_e_ra[gi]);
            assign w_w_hit = r_e_valid && (r_e_ra[gi] != c_pc_addr) && w_regwrite && (w_wa == r_e_ra[gi]);
            assign w_e_op[gi] = w_m_hit ? m_result : (w_w_hit ? w_result : r_e_rd[gi]);
         end else begin : g_raw
            assign w_e_op[gi] = r_e_rd[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e_valid    <= 1'b0;
         r_e_regwrite <= 1'b0;
         r_e_memtoreg <= 1'b0;
         r_e_wa       <= '0;
         r_e_ctrl     <= '0;
         r_e_ra       <= '0;
         r_e_rd       <= '0;
      end else begin
         r_e_wa   <= d_wa;
         r_e_ctrl <= d_ctrl;
         r_e_ra   <= w_d_ra;
         r_e_rd   <= w_cap_rd;
         // Flush and load-use both leave a bubble; data fields are don't-care then.
         if (flush_e || w_lduse) begin
            r_e_valid    <= 1'b0;
            r_e_regwrite <= 1'b0;
            r_e_memtoreg <= 1'b0;
         end else begin
            r_e_valid    <= d_valid;
            r_e_regwrite <= d_valid & d_regwrite;
            r_e_memtoreg <= d_valid & d_memtoreg;
         end
      end
   end

   assign e_valid    = r_e_valid;
   assign e_regwrite = r_e_regwrite;
   assign e_memtoreg = r_e_memtoreg;
   assign e_wa       = r_e_wa;
   assign e_ctrl     = r_e_ctrl;
   assign e_op1      = w_e_op[0];
   assign e_op2      = w_e_op[1];
   assign e_op3      = w_e_op[2];

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_execute_stage
// Purpose  : Random + directed scoreboard bench for decode_execute_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        d_valid;
   logic [3:0]  d_ra [3];
   logic [31:0] d_rd [3];
   logic [3:0]  d_wa;
   logic        d_regwrite;
   logic        d_memtoreg;
   logic [7:0]  d_ctrl;
   logic [3:0]  m_wa;
   logic        m_regwrite;
   logic [31:0] m_result;
   logic [3:0]  w_wa;
   logic        w_regwrite;
   logic [31:0] w_result;
   logic        flush_e;
   logic        stall_d;
   logic        e_valid;
   logic [31:0] e_op [3];
   logic [3:0]  e_wa;
   logic        e_regwrite;
   logic        e_memtoreg;
   logic [7:0]  e_ctrl;

   decode_execute_stage #(.CTRL_W(8), .FWD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .d_ra1(d_ra[0]), .d_ra2(d_ra[1]), .d_ra3(d_ra[2]),
      .d_rd1(d_rd[0]), .d_rd2(d_rd[1]), .d_rd3(d_rd[2]),
      .d_wa(d_wa), .d_regwrite(d_regwrite), .d_memtoreg(d_memtoreg), .d_ctrl(d_ctrl),
      .m_wa(m_wa), .m_regwrite(m_regwrite), .m_result(m_result),
      .w_wa(w_wa), .w_regwrite(w_regwrite), .w_result(w_result),
      .flush_e(flush_e), .stall_d(stall_d), .e_valid(e_valid),
      .e_op1(e_op[0]), .e_op2(e_op[1]), .e_op3(e_op[2]),
      .e_wa(e_wa), .e_regwrite(e_regwrite), .e_memtoreg(e_memtoreg), .e_ctrl(e_ctrl)
   );

   always #5 clk = ~clk;

   // What the E stage architecturally holds: the instruction and the operand
   // values it read (after register-file write-through).
   typedef struct {
      bit               valid;
      bit               rw;
      bit               mtr;
      logic [3:0]       wa;
      logic [7:0]       ctrl;
      logic [2:0][3:0]  ra;
      logic [2:0][31:0] val;
   } e_t;

   e_t  mdl;
   e_t  exp_q [$];
   bit  stall_q [$];
   bit  mon_en = 1'b0;
   int  total = 0;
   int  passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic e_t empty_e();
      e_t z;
      z.valid = 1'b0; z.rw = 1'b0; z.mtr = 1'b0;
      z.wa = '0; z.ctrl = '0; z.ra = '0; z.val = '0;
      return z;
   endfunction

   function automatic logic [3:0] rnd_addr();
      int r = $urandom_range(0, 4);
      return (r == 4) ? 4'd15 : 4'(r);
   endfunction

   task automatic drive_random();
      d_valid    = ($urandom_range(0, 9) < 8);
      for (int n = 0; n < 3; n++) begin
         d_ra[n] = rnd_addr();
         d_rd[n] = $urandom;
      end
      d_wa       = rnd_addr();
      d_regwrite = 1'($urandom_range(0, 1));
      d_memtoreg = ($urandom_range(0, 2) == 0);
      d_ctrl     = 8'($urandom);
      m_wa       = rnd_addr();
      m_regwrite = 1'($urandom_range(0, 1));
      m_result   = $urandom;
      w_wa       = rnd_addr();
      w_regwrite = 1'($urandom_range(0, 1));
      w_result   = $urandom;
      flush_e    = ($urandom_range(0, 9) == 0);
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      #1;
      drive_random();
   endtask

   // Predict this cycle's stall and the E contents after the coming edge.
   task automatic model_step();
      bit lduse = 1'b0;
      e_t nxt = empty_e();
      for (int n = 0; n < 3; n++)
         if (mdl.valid && mdl.mtr && d_valid && d_ra[n] != 4'd15 && d_ra[n] == mdl.wa) lduse = 1'b1;
      stall_q.push_back(lduse && !flush_e);
      if (!flush_e && !lduse && d_valid) begin
         nxt.valid = 1'b1;
         nxt.rw    = d_regwrite;
         nxt.mtr   = d_memtoreg;
         nxt.wa    = d_wa;
         nxt.ctrl  = d_ctrl;
         for (int n = 0; n < 3; n++) begin
            nxt.ra[n]  = d_ra[n];
            nxt.val[n] = (w_regwrite && w_wa == d_ra[n] && d_ra[n] != 4'd15) ? w_result : d_rd[n];
         end
      end
      exp_q.push_back(nxt);
      mdl = nxt;
   endtask

   function automatic logic [31:0] fwd(input logic [3:0] ra, input logic [31:0] val);
      if (ra == 4'd15) return val;
      if (m_regwrite && m_wa == ra) return m_result;
      if (w_regwrite && w_wa == ra) return w_result;
      return val;
   endfunction

   always @(negedge clk) begin
      e_t e;
      bit s;
      if (mon_en) begin
         if (exp_q.size() == 0 || stall_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
         end else begin
            e = exp_q.pop_front();
            s = stall_q.pop_front();
            chk("stall_d", stall_d, s);
            chk("e_valid", e_valid, e.valid);
            chk("e_regwrite", e_regwrite, e.rw);
            chk("e_memtoreg", e_memtoreg, e.mtr);
            if (e.valid) begin
               chk("e_wa", e_wa, e.wa);
               chk("e_ctrl", e_ctrl, e.ctrl);
               for (int n = 0; n < 3; n++)
                  chk($sformatf("e_op%0d", n + 1), e_op[n], fwd(e.ra[n], e.val[n]));
            end
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst e_valid", e_valid, 0);
      chk("rst e_regwrite", e_regwrite, 0);
      chk("rst e_memtoreg", e_memtoreg, 0);
      chk("rst e_wa", e_wa, 0);
      chk("rst e_ctrl", e_ctrl, 0);
      chk("rst stall_d", stall_d, 0);
      for (int n = 0; n < 3; n++) chk($sformatf("rst e_op%0d", n + 1), e_op[n], 0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      stall_q.delete();
      mdl = empty_e();
      exp_q.push_back(mdl);
      drive_random();
      model_step();
      mon_en = 1'b1;
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      drive_random();
      reset = 1'b1;
      #1;
      check_reset_outputs();
      release_reset();
   endtask

   task automatic idle();
      begin_cycle();
      d_valid = 1'b0;
      flush_e = 1'b0;
      model_step();
   endtask

   task automatic run_random(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         begin_cycle();
         model_step();
      end
   endtask

   task automatic load_use(input bit flush);
      idle();
      begin_cycle();
      d_valid = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1; d_wa = 4'd2; flush_e = 1'b0;
      model_step();
      begin_cycle();
      d_valid = 1'b1; d_memtoreg = 1'b0; d_ra[1] = 4'd2; flush_e = flush;
      model_step();
      begin_cycle();
      d_valid = 1'b1; d_memtoreg = 1'b0; d_ra[1] = 4'd2; flush_e = 1'b0;
      model_step();
      idle();
   endtask

   initial begin
      reset = 1'b1;
      drive_random();
      #1;
      check_reset_outputs();
      release_reset();
      run_random(300);
      mid_reset();

      // MEM and WB both target r1: MEM wins.
      idle();
      begin_cycle();
      d_valid = 1'b1; d_ra[0] = 4'd1; d_memtoreg = 1'b0; w_regwrite = 1'b0; flush_e = 1'b0;
      model_step();
      begin_cycle();
      m_wa = 4'd1; m_regwrite = 1'b1; m_result = 32'h11;
      w_wa = 4'd1; w_regwrite = 1'b1; w_result = 32'h22;
      model_step();

      // WB writes r3 on the capture edge.
      idle();
      begin_cycle();
      d_valid = 1'b1; d_ra[2] = 4'd3; d_rd[2] = 32'h0000BAD0; d_memtoreg = 1'b0; flush_e = 1'b0;
      w_wa = 4'd3; w_regwrite = 1'b1; w_result = 32'h0000DEAD;
      model_step();
      begin_cycle();
      m_regwrite = 1'b0; w_regwrite = 1'b0;
      model_step();

      load_use(1'b0);
      load_use(1'b1);

      // PC reads are never bypassed or forwarded.
      idle();
      begin_cycle();
      d_valid = 1'b1; d_ra[0] = 4'd15; d_rd[0] = 32'h00008000; d_memtoreg = 1'b0; flush_e = 1'b0;
      w_wa = 4'd15; w_regwrite = 1'b1;
      model_step();
      begin_cycle();
      m_wa = 4'd15; m_regwrite = 1'b1; w_wa = 4'd15; w_regwrite = 1'b1;
      model_step();

      run_random(1500);
      mid_reset();
      run_random(200);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
